// File: rtl/xnor_bist_ctrl_if.sv
// Control/observe bundle between a test-control register, the BIST sequencer and an Xnor2 gate.
// Defining XNOR_BIST_ERRLOG_EN adds the first-error log signals.
interface xnor_bist_ctrl_if;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic       gate_x;
    logic       gate_y;
    logic       gate_z;
`ifdef XNOR_BIST_ERRLOG_EN
    logic       first_err_valid;
    logic [1:0] first_err_vec;
    logic       first_err_z;

    modport master (
        output start, abort, gate_z,
        input  busy, done, pass, fail_mask, gate_x, gate_y,
        input  first_err_valid, first_err_vec, first_err_z
    );
    modport slave (
        input  start, abort, gate_z,
        output busy, done, pass, fail_mask, gate_x, gate_y,
        output first_err_valid, first_err_vec, first_err_z
    );
`else
    modport master (
        output start, abort, gate_z,
        input  busy, done, pass, fail_mask, gate_x, gate_y
    );
    modport slave (
        input  start, abort, gate_z,
        output busy, done, pass, fail_mask, gate_x, gate_y
    );
`endif
endinterface

// File: rtl/xnor_bist_ctrl.sv
// BIST sequencer for one external Xnor2: applies 00,01,10,11, holds each HOLD_CYCLES cycles, checks z.
// Optional first-error log enabled by defining XNOR_BIST_ERRLOG_EN.
module xnor_bist_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    xnor_bist_ctrl_if.slave   bif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_DONE
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q;
    logic [1:0]       vec_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [3:0]       fail_mask_q;
    logic             gate_x_q;
    logic             gate_y_q;

    logic             expected_z;
    logic             mismatch;
    logic             sample;
    logic [1:0]       vec_d;
    logic [3:0]       fail_mask_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        expected_z  = ~(vec_q[1] ^ vec_q[0]);
        // NOTE: an X/Z on gate_z makes the equality unknown, so the if falls through and it stays a mismatch.
        mismatch    = 1'b1;
        if (bif.gate_z == expected_z) begin
            mismatch = 1'b0;
        end
        sample      = (state_q == ST_APPLY) && (cnt_q == '0) && !bif.abort;
        vec_d       = vec_q + 2'd1;
        fail_mask_d = fail_mask_q;
        if (sample) begin
            fail_mask_d[vec_q] = mismatch;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= 2'd0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'b0000;
            gate_x_q    <= 1'b0;
            gate_y_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bif.start) begin
                        state_q     <= ST_APPLY;
                        vec_q       <= 2'd0;
                        cnt_q       <= HOLD_RELOAD;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_mask_q <= 4'b0000;
                        gate_x_q    <= 1'b0;
                        gate_y_q    <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (bif.abort) begin
                        state_q     <= ST_IDLE;
                        vec_q       <= 2'd0;
                        cnt_q       <= '0;
                        busy_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_mask_q <= 4'b0000;
                        gate_x_q    <= 1'b0;
                        gate_y_q    <= 1'b0;
                    end else if (sample) begin
                        fail_mask_q <= fail_mask_d;
                        if (vec_q == 2'd3) begin
                            state_q  <= ST_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            pass_q   <= (fail_mask_d == 4'b0000);
                            gate_x_q <= 1'b0;
                            gate_y_q <= 1'b0;
                        end else begin
                            vec_q    <= vec_d;
                            cnt_q    <= HOLD_RELOAD;
                            gate_x_q <= vec_d[1];
                            gate_y_q <= vec_d[0];
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bif.busy      = busy_q;
    assign bif.done      = done_q;
    assign bif.pass      = pass_q;
    assign bif.fail_mask = fail_mask_q;
    assign bif.gate_x    = gate_x_q;
    assign bif.gate_y    = gate_y_q;

`ifdef XNOR_BIST_ERRLOG_EN
    logic       first_err_valid_q;
    logic [1:0] first_err_vec_q;
    logic       first_err_z_q;
    logic       log_clear;

    assign log_clear = ((state_q == ST_IDLE) && bif.start) ||
                       ((state_q == ST_APPLY) && bif.abort);

    always_ff @(posedge clk) begin
        if (rst || log_clear) begin
            first_err_valid_q <= 1'b0;
            first_err_vec_q   <= 2'd0;
            first_err_z_q     <= 1'b0;
        end else if (sample && mismatch && !first_err_valid_q) begin
            first_err_valid_q <= 1'b1;
            first_err_vec_q   <= vec_q;
            first_err_z_q     <= bif.gate_z;
        end
    end

    assign bif.first_err_valid = first_err_valid_q;
    assign bif.first_err_vec   = first_err_vec_q;
    assign bif.first_err_z     = first_err_z_q;
`else
    // Without the error log only the pass/fail_mask summary is reported.
`endif

endmodule
